// File: rtl/output_image_dma_if.sv
// Port bundle of the output image DMA channel: memory read port, request/status and outputs.
// With OUT_SAFE_EN defined it also carries the SAFE force-to-zero input.
interface output_image_dma_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              START;
  logic [ADDR_W-1:0] A;
  logic              DQ;
  logic              BUSY;
  logic              DONE;
  logic [15:0]       OUT;
`ifdef OUT_SAFE_EN
  logic              SAFE;
`endif

  modport master (
`ifdef OUT_SAFE_EN
    input  SAFE,
`endif
    input  START,
    input  DQ,
    output A,
    output BUSY,
    output DONE,
    output OUT
  );

  modport slave (
`ifdef OUT_SAFE_EN
    output SAFE,
`endif
    output START,
    output DQ,
    input  A,
    input  BUSY,
    input  DONE,
    input  OUT
  );
endinterface

// File: rtl/output_image_dma.sv
// Output image DMA: sweeps BASE..BASE+15 into a shadow register and commits OUT in one edge.
// Optional feature macro OUT_SAFE_EN adds SAFE, which holds OUT at zero while asserted.
module output_image_dma #(
  parameter int unsigned       ADDR_W = 5,
  parameter logic [ADDR_W-1:0] BASE   = 5'b10000
) (
  input  logic                CLK,
  input  logic                CLR,
  output_image_dma_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StCommit} state_e;

  state_e            state_q;
  logic [3:0]        idx_q;
  logic [3:0]        idx_dly_q;
  logic              cap_q;
  logic [15:0]       shadow_q;
  logic [ADDR_W-1:0] a_q;
  logic              busy_q;
  logic              done_q;
  logic [15:0]       out_q;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      idx_dly_q <= '0;
      cap_q     <= 1'b0;
      shadow_q  <= '0;
      a_q       <= BASE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      out_q     <= '0;
    end else begin
      done_q    <= 1'b0;
      cap_q     <= 1'b0;
      idx_dly_q <= idx_q;
      // Read data lags the address by one cycle, so capture uses the delayed index.
      if (cap_q) begin
        shadow_q[idx_dly_q] <= bus.DQ;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.START) begin
            state_q <= StFetch;
            idx_q   <= '0;
            a_q     <= BASE;
            busy_q  <= 1'b1;
          end
        end
        StFetch: begin
          cap_q <= 1'b1;
          idx_q <= idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_q <= StDrain;
            a_q     <= BASE;
          end else begin
            a_q <= BASE + ADDR_W'(idx_q) + ADDR_W'(1);
          end
        end
        StDrain: begin
          state_q <= StCommit;
        end
        StCommit: begin
          out_q   <= shadow_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
`ifdef OUT_SAFE_EN
      if (bus.SAFE) begin
        out_q <= '0;
      end
`endif
    end
  end

  assign bus.A    = a_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.OUT  = out_q;

endmodule

// File: tb/tb_output_image_dma.sv
// Self-checking bench for output_image_dma: directed steps, expected OUT values queued per
// accepted START and popped when DONE appears.
module tb_output_image_dma;
  localparam int unsigned ADDR_W = 5;
  localparam logic [4:0]  BASE   = 5'b10000;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  output_image_dma_if #(.ADDR_W(ADDR_W)) bus ();

  output_image_dma #(
    .ADDR_W (ADDR_W),
    .BASE   (BASE)
  ) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  // Image memory with a registered read port.
  logic mem [32];
  always @(posedge clk) bus.DQ <= mem[bus.A];

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    for (int i = 0; i < 16; i++) mem[int'(BASE) + i] = v[i];
  endtask

  // Scoreboard side: every DONE must match the oldest queued expectation.
  always @(negedge clk) begin
    if (clr === 1'b0) begin
      if (bus.DONE === 1'b1) begin
        tests++;
        assert (exp_q.size() > 0) else begin
          fails++;
          $error("FAIL spurious_done: observed DONE=1 expected no DONE");
        end
        if (exp_q.size() > 0) check("out_on_done", 32'(bus.OUT), 32'(exp_q.pop_front()));
      end
      check("busy_done_excl", 32'(bus.BUSY & bus.DONE), 32'(0));
    end
  end

  // Loads memory, starts one transfer and checks the START-to-DONE latency.
  task automatic run_xfer(input logic [15:0] v, input logic [15:0] exp_out);
    int n;
    load(v);
    exp_q.push_back(exp_out);
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    n = 1;
    while (bus.DONE !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'(19));
  endtask

  initial begin
    logic [15:0] w;
    clr       = 1'b1;
    bus.START = 1'b0;
`ifdef OUT_SAFE_EN
    bus.SAFE  = 1'b0;
`endif
    for (int i = 0; i < 32; i++) mem[i] = 1'b0;

    // Reset
    tick();
    tick();
    check("rst_out", 32'(bus.OUT), 32'(0));
    check("rst_a", 32'(bus.A), 32'(16));
    check("rst_busy", 32'(bus.BUSY), 32'(0));
    check("rst_done", 32'(bus.DONE), 32'(0));
    clr = 1'b0;
    tick();

    // Basic transfer with cycle-by-cycle timing
    load(16'hA5C3);
    exp_q.push_back(16'hA5C3);
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      check($sformatf("a_c%0d", c), 32'(bus.A), (c <= 16) ? 32'(16 + c - 1) : 32'(16));
      check($sformatf("busy_c%0d", c), 32'(bus.BUSY), (c <= 18) ? 32'(1) : 32'(0));
      check($sformatf("done_c%0d", c), 32'(bus.DONE), (c == 19) ? 32'(1) : 32'(0));
      check($sformatf("out_c%0d", c), 32'(bus.OUT), (c == 19) ? 32'hA5C3 : 32'(0));
      if (c < 19) tick();
    end
    tick();
    check("done_c20", 32'(bus.DONE), 32'(0));
    check("out_hold_c20", 32'(bus.OUT), 32'hA5C3);

    // Ignored START mid-transfer; bits 0..3 already read from the old image
    exp_q.push_back(16'h0F03);
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    load(16'h0F0F);
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    for (int c = 6; c < 19; c++) begin
      check($sformatf("ign_nodone_c%0d", c), 32'(bus.DONE), 32'(0));
      tick();
    end
    check("ign_done_c19", 32'(bus.DONE), 32'(1));
    // Back-to-back START in the DONE cycle
    exp_q.push_back(16'h0F0F);
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    for (int c = 20; c < 38; c++) begin
      check($sformatf("b2b_busy_c%0d", c), 32'(bus.BUSY), 32'(1));
      tick();
    end
    check("b2b_done_c38", 32'(bus.DONE), 32'(1));
    check("b2b_out_c38", 32'(bus.OUT), 32'h0F0F);
    tick();

    // Abort with CLR in cycle 10
    run_xfer(16'hFFFF, 16'hFFFF);
    tick();
    load(16'h1357);
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("abort_out", 32'(bus.OUT), 32'(0));
    check("abort_busy", 32'(bus.BUSY), 32'(0));
    check("abort_a", 32'(bus.A), 32'(16));
    check("abort_done", 32'(bus.DONE), 32'(0));
    for (int c = 0; c < 25; c++) tick();
    check("abort_busy_late", 32'(bus.BUSY), 32'(0));
    run_xfer(16'h5A3C, 16'h5A3C);
    tick();

    // Walking one
    for (int i = 0; i < 16; i++) begin
      w = 16'(1) << i;
      run_xfer(w, w);
      check($sformatf("walk_%0d", i), 32'(bus.OUT), 32'(w));
      tick();
    end

`ifdef OUT_SAFE_EN
    bus.SAFE = 1'b1;
    run_xfer(16'h1234, 16'h0000);
    check("safe_out", 32'(bus.OUT), 32'(0));
    tick();
    bus.SAFE = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    check("safe_release_out", 32'(bus.OUT), 32'(0));
    run_xfer(16'h1234, 16'h1234);
    check("safe_next_out", 32'(bus.OUT), 32'h1234);
    tick();
`endif

    for (int c = 0; c < 3; c++) tick();
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
